// File: rtl/systolic_pkg.sv
// Shared configuration and arithmetic helpers for the weight-stationary
// double-buffered processing element.
package systolic_pkg;

  localparam int SAT_BOUND_W = 64;

  typedef struct packed {
    int in_w;
    int w_w;
    int acc_w;
    bit signed_m;
    bit saturate;
    bit pipe_mult;
  } pe_cfg_t;

  localparam pe_cfg_t PE_CFG_DEF = '{
    in_w:      16,
    w_w:       16,
    acc_w:     32,
    signed_m:  1'b1,
    saturate:  1'b0,
    pipe_mult: 1'b0
  };

  function automatic bit acc_fits(int iw, int ww, int aw);
    return aw >= iw + ww;
  endfunction

  // Sum width: one guard bit over whichever is wider, so a narrow
  // saturating accumulator still sees the full product before clamping.
  function automatic int ext_width(int iw, int ww, int aw);
    return (acc_fits(iw, ww, aw) ? aw : iw + ww) + 1;
  endfunction

  function automatic logic [SAT_BOUND_W-1:0] sat_bound(
    int acc_w,
    bit is_signed,
    bit upper
  );
    logic [SAT_BOUND_W-1:0] one;
    logic [SAT_BOUND_W-1:0] half;
    one  = {{(SAT_BOUND_W-1){1'b0}}, 1'b1};
    half = (one << (acc_w - 1)) - one;
    if (is_signed)
      return upper ? half : ~half;
    return upper ? (one << acc_w) - one : '0;
  endfunction

endpackage

// File: rtl/ws_mac_stage.sv
// Multiply-accumulate datapath: product, optional product register,
// extension, and wrap or saturate into the partial-sum register.
module ws_mac_stage
  import systolic_pkg::*;
#(
  parameter int IW   = 16,
  parameter int WW   = 16,
  parameter int AW   = 32,
  parameter int SGN  = 1,
  parameter int SAT  = 0,
  parameter int PIPE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [IW-1:0] i_act,
  input  logic [WW-1:0] i_wgt,
  input  logic [AW-1:0] i_psum,
  output logic [AW-1:0] o_psum,
  output logic          o_psum_valid,
  output logic          o_clamp
);

  localparam int PW = IW + WW;
  localparam int SW = ext_width(IW, WW, AW);

  logic          w_xa;
  logic          w_xw;
  logic [PW-1:0] w_prod;

  assign w_xa = (SGN != 0) & i_act[IW-1];
  assign w_xw = (SGN != 0) & i_wgt[WW-1];

  // Extending both operands to the product width makes one multiplier
  // serve signed and unsigned: the low PW bits are exact in both cases.
  assign w_prod = {{WW{w_xa}}, i_act} * {{IW{w_xw}}, i_wgt};

  logic          w_v;
  logic [PW-1:0] w_p;
  logic [AW-1:0] w_c;

  generate
    if (PIPE != 0) begin : g_pipe
      logic          r_v;
      logic [PW-1:0] r_p;
      logic [AW-1:0] r_c;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v <= 1'b0;
          r_p <= '0;
          r_c <= '0;
        end else begin
          r_v <= i_valid;
          if (i_valid) begin
            r_p <= w_prod;
            r_c <= i_psum;
          end
        end
      end

      assign w_v = r_v;
      assign w_p = r_p;
      assign w_c = r_c;
    end else begin : g_flat
      assign w_v = i_valid;
      assign w_p = w_prod;
      assign w_c = i_psum;
    end
  endgenerate

  logic          w_pe_s;
  logic          w_ce_s;
  logic [SW-1:0] w_pext;
  logic [SW-1:0] w_cext;
  logic [SW-1:0] w_sum;

  assign w_pe_s = (SGN != 0) & w_p[PW-1];
  assign w_ce_s = (SGN != 0) & w_c[AW-1];
  assign w_pext = {{(SW-PW){w_pe_s}}, w_p};
  assign w_cext = {{(SW-AW){w_ce_s}}, w_c};
  assign w_sum  = w_pext + w_cext;

  logic [AW-1:0] w_res;
  logic          w_hit;

  generate
    if (SAT == 0) begin : g_wrap
      logic w_unused_hi;
      assign w_unused_hi = ^w_sum[SW-1:AW];
      assign w_res = w_sum[AW-1:0];
      assign w_hit = 1'b0;
    end else if (SGN != 0) begin : g_ssat
      localparam logic [SAT_BOUND_W-1:0] HI64 =
        sat_bound(AW, 1'b1, 1'b1);
      localparam logic [SAT_BOUND_W-1:0] LO64 =
        sat_bound(AW, 1'b1, 1'b0);
      localparam logic [SW-1:0] HI = HI64[SW-1:0];
      localparam logic [SW-1:0] LO = LO64[SW-1:0];

      logic w_over;
      logic w_under;

      assign w_over  = $signed(w_sum) > $signed(HI);
      assign w_under = $signed(w_sum) < $signed(LO);
      assign w_res   = w_over  ? HI[AW-1:0] :
                       w_under ? LO[AW-1:0] : w_sum[AW-1:0];
      assign w_hit   = w_over | w_under;
    end else begin : g_usat
      localparam logic [SAT_BOUND_W-1:0] HI64 =
        sat_bound(AW, 1'b0, 1'b1);
      localparam logic [SW-1:0] HI = HI64[SW-1:0];

      logic w_over;

      assign w_over = w_sum > HI;
      assign w_res  = w_over ? HI[AW-1:0] : w_sum[AW-1:0];
      assign w_hit  = w_over;
    end
  endgenerate

  logic [AW-1:0] r_psum;
  logic          r_psum_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psum   <= '0;
      r_psum_v <= 1'b0;
    end else begin
      r_psum_v <= w_v;
      if (w_v)
        r_psum <= w_res;
    end
  end

  assign o_psum       = r_psum;
  assign o_psum_valid = r_psum_v;
  assign o_clamp      = w_v & w_hit;

endmodule

// File: rtl/ws_pe_db.sv
// Weight-stationary PE with double-buffered weights: shadow/active
// registers, activation forwarding, MAC datapath and sticky overflow.
module ws_pe_db
  import systolic_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int W_WIDTH   = 16,
  parameter int ACC_WIDTH = 32,
  parameter int SIGNED    = 1,
  parameter int SATURATE  = 0,
  parameter int PIPE_MULT = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_in,
  input  logic [IN_WIDTH-1:0]  input_in,
  input  logic [ACC_WIDTH-1:0] psum_in,
  input  logic                 weight_load,
  input  logic [W_WIDTH-1:0]   weight_in,
  input  logic                 weight_swap,
  input  logic                 clear_ovf,
  output logic [IN_WIDTH-1:0]  input_out,
  output logic                 valid_out,
  output logic [W_WIDTH-1:0]   weight_out,
  output logic [ACC_WIDTH-1:0] psum_out,
  output logic                 psum_valid,
  output logic                 ovf
);

  localparam pe_cfg_t CFG = '{
    in_w:      IN_WIDTH,
    w_w:       W_WIDTH,
    acc_w:     ACC_WIDTH,
    signed_m:  SIGNED != 0,
    saturate:  SATURATE != 0,
    pipe_mult: PIPE_MULT != 0
  };

  logic [W_WIDTH-1:0]  r_shadow;
  logic [W_WIDTH-1:0]  r_active;
  logic [IN_WIDTH-1:0] r_in_out;
  logic                r_v_out;
  logic                r_ovf;
  logic                w_clamp;

  // Both registers update from pre-edge values, so a simultaneous
  // load and swap moves the old shadow to active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (weight_load)
        r_shadow <= weight_in;
      if (weight_swap)
        r_active <= r_shadow;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_out <= '0;
      r_v_out  <= 1'b0;
    end else begin
      r_v_out <= valid_in;
      if (valid_in)
        r_in_out <= input_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_ovf <= 1'b0;
    else if (w_clamp)
      r_ovf <= 1'b1;
    else if (clear_ovf)
      r_ovf <= 1'b0;
  end

  ws_mac_stage #(
    .IW   (CFG.in_w),
    .WW   (CFG.w_w),
    .AW   (CFG.acc_w),
    .SGN  (int'(CFG.signed_m)),
    .SAT  (int'(CFG.saturate)),
    .PIPE (int'(CFG.pipe_mult))
  ) u_mac (
    .clk          (clk),
    .rst_n        (reset_n),
    .i_valid      (valid_in),
    .i_act        (input_in),
    .i_wgt        (r_active),
    .i_psum       (psum_in),
    .o_psum       (psum_out),
    .o_psum_valid (psum_valid),
    .o_clamp      (w_clamp)
  );

  assign input_out  = r_in_out;
  assign valid_out  = r_v_out;
  assign weight_out = r_shadow;
  assign ovf        = r_ovf;

endmodule

// File: doc/ws_pe_db.md
WS_PE_DB -- requirements
Module: ws_pe_db

Interface
REQ-001 Parameter IN_WIDTH, default 16: activation bit width.
REQ-002 Parameter W_WIDTH, default 16: weight bit width.
REQ-003 Parameter ACC_WIDTH, default 32: partial-sum bit width; must be at least IN_WIDTH+W_WIDTH, or SATURATE=1.
REQ-004 Parameter SIGNED, default 1: 1 = two's-complement arithmetic, 0 = unsigned.
REQ-005 Parameter SATURATE, default 0: 1 = clamp the accumulate result, 0 = wrap.
REQ-006 Parameter PIPE_MULT, default 0: 1 = add one product register stage.
REQ-007 Ports (clock and reset first): clk in 1 clock; reset_n in 1 reset, asynchronous and active-low.
REQ-008 Ports: valid_in in 1; input_in in IN_WIDTH; psum_in in ACC_WIDTH.
REQ-009 Ports: weight_load in 1 shifts weight_in into the shadow register; weight_in in W_WIDTH; weight_swap in 1 commits shadow to active.
REQ-010 Ports: clear_ovf in 1 clears the sticky overflow flag.
REQ-011 Ports: input_out out IN_WIDTH; valid_out out 1; weight_out out W_WIDTH = shadow register (daisy-chain to the PE below).
REQ-012 Ports: psum_out out ACC_WIDTH; psum_valid out 1; ovf out 1 sticky overflow flag.

Function
REQ-013 Shadow update: on weight_load, shadow <= weight_in; otherwise shadow holds.
REQ-014 Swap: on weight_swap, active <= shadow as it stood before that edge.
REQ-015 Load and swap in the same cycle: active gets the old shadow; shadow gets weight_in.
REQ-016 Data with valid_in in the same cycle as weight_swap uses the old active weight; the new weight applies from the next cycle.
REQ-017 Activation forwarding: input_out and valid_out are registered copies of input_in and valid_in, latency 1.
REQ-018 input_out holds its value when valid_in=0; valid_out drops to 0.
REQ-019 Product: input_in * active, IN_WIDTH+W_WIDTH bits, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH+1 bits.
REQ-020 Sum: extended product + extended psum_in, computed in ACC_WIDTH+1 bits.
REQ-021 Sampling: psum_in is sampled together with input_in on valid_in; when PIPE_MULT=1 it is delayed internally alongside the product.
REQ-022 Latency from valid_in to psum_valid is 1+PIPE_MULT cycles; psum_out holds its value when no result is produced.
REQ-023 SATURATE=0: psum_out = low ACC_WIDTH bits of the sum; ovf stays 0.
REQ-024 SATURATE=1, SIGNED=1: a sum above max clamps to 2^(ACC_WIDTH-1)-1 and a sum below min clamps to -2^(ACC_WIDTH-1).
REQ-025 SATURATE=1, SIGNED=0: a sum above max clamps to 2^ACC_WIDTH-1.
REQ-026 SATURATE=1: any clamp sets ovf to 1 on the same edge that psum_valid is asserted.
REQ-027 ovf stays 1 until clear_ovf or reset; if clear_ovf and a new clamp occur in the same cycle, the set wins.
REQ-028 Pipeline stages advance only on valid; a bubble propagates as psum_valid=0.
REQ-029 There is no back-pressure.

Reset
REQ-030 reset_n low asynchronously clears shadow, active, every pipeline register, input_out, valid_out, psum_out, psum_valid, weight_out and ovf to 0.
REQ-031 Reset mid-operation discards in-flight results; the first psum_valid after release is driven by a valid_in accepted after release.

Structure
REQ-032 Package systolic_pkg holds the saturation-bound function, ACC-width check constants and a shared pe_cfg_t parameter struct.
REQ-033 One sub-module ws_mac_stage contains the multiply, optional product register, extension and saturate/wrap; ws_pe_db holds the weight registers, forwarding and flags.

Verification
REQ-034 Signed, 16/16/32, PIPE_MULT=0: load 16'hFFFE (-2), swap, valid_in with input_in=3 and psum_in=10 -> psum_out=4 and psum_valid=1 one cycle later.
REQ-035 Swap timing: active=2, shadow=5; weight_swap and valid_in with input_in=1 and psum_in=0 in the same cycle, then input_in=1 the next cycle -> psum_out 2 then 5.
REQ-036 Saturation, ACC_WIDTH=16, SATURATE=1, signed: weight=1, psum_in=32767, input_in=1 -> psum_out=32767 and ovf=1; clear_ovf -> ovf=0.
REQ-037 PIPE_MULT=1: valid_in high for 3 cycles with inputs 1, 2, 3, weight 4, psum_in 0 -> psum_valid on cycles 2-4 with 4, 8, 12; valid_out on cycles 1-3.
REQ-038 Daisy chain: weight_load for 2 cycles with 7 then 9 -> weight_out = 7 then 9; active unchanged until weight_swap.
REQ-039 Reset during PIPE_MULT=1 flight: assert reset_n=0 one cycle after valid_in -> all outputs 0 immediately, and no psum_valid after release.
